// File: rtl/commit_trace_unit_pkg.sv
// rtl/commit_trace_unit_pkg.sv - shared state codes, fault causes and widths for the commit trace unit
package commit_trace_unit_pkg;

  localparam int PC_WIDTH = 32;
  localparam int DROP_W   = 16;

  typedef enum logic [1:0] {
    TRC_IDLE  = 2'b00,
    TRC_RUN   = 2'b01,
    TRC_HALT  = 2'b10,
    TRC_FAULT = 2'b11
  } trc_state_e;

  typedef enum logic [1:0] {
    FC_NONE        = 2'b00,
    FC_PC_MISMATCH = 2'b01,
    FC_TIMEOUT     = 2'b10,
    FC_AFTER_HALT  = 2'b11
  } fault_cause_e;

  // Record layout, MSB first: {seq, pc, npc, err}
  function automatic int rec_width(input int seq_w, input int pc_w);
    return seq_w + 2 * pc_w + 1;
  endfunction

endpackage

// File: rtl/commit_trace_unit_trace_fifo.sv
// rtl/commit_trace_unit_trace_fifo.sv - registered show-ahead record FIFO with valid/ready drain
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_full,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic w_empty;
  logic w_pop;
  logic w_write;

  // Same index with differing wrap bits means the writer has lapped the reader.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_valid = !w_empty;
  assign w_pop   = o_valid && i_ready;
  assign w_write = i_push && (!o_full || w_pop);
  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_write) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        r_wr_ptr                <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
    end
  end

endmodule

// File: rtl/commit_trace_unit.sv
// rtl/commit_trace_unit.sv - retirement stream checker: PC continuity, halt/stall detection, numbered trace
module commit_trace_unit
  import commit_trace_unit_pkg::*;
#(
  parameter int PC_W    = PC_WIDTH,
  parameter int DEPTH   = 16,
  parameter int SEQ_W   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              commit,
  input  logic [PC_W-1:0]   commit_pc,
  input  logic [PC_W-1:0]   commit_pre_pc,
  output logic              trace_valid,
  input  logic              trace_ready,
  output logic [SEQ_W-1:0]  trace_seq,
  output logic [PC_W-1:0]   trace_pc,
  output logic [PC_W-1:0]   trace_npc,
  output logic              trace_err,
  output logic [1:0]        state_o,
  output logic [1:0]        fault_cause,
  output logic [PC_W-1:0]   fault_pc,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_cnt,
  output logic [SEQ_W-1:0]  retired
);

  localparam int REC_W = rec_width(SEQ_W, PC_W);
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  trc_state_e        r_state;
  trc_state_e        w_next_state;
  fault_cause_e      w_fault_event;
  fault_cause_e      r_fault_cause;
  logic [PC_W-1:0]   r_fault_pc;
  logic [PC_W-1:0]   r_expected;
  logic [PC_W-1:0]   r_halt_pc;
  logic [SEQ_W-1:0]  r_retired;
  logic [WD_W-1:0]   r_wdog;
  logic              r_overflow;
  logic [DROP_W-1:0] r_drop_cnt;

  logic              w_halt_hit;
  logic              w_accept;
  logic              w_err;
  logic              w_self_loop;
  logic              w_timeout;
  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic [REC_W-1:0]  w_rec_in;
  logic [REC_W-1:0]  w_rec_out;

  // A halted core keeps re-retiring its self-loop; those repeats carry no information.
  assign w_halt_hit  = (r_state == TRC_HALT) && (commit_pc == r_halt_pc);
  assign w_accept    = commit && !w_halt_hit;
  assign w_err       = commit && ((r_state == TRC_RUN) || (r_state == TRC_FAULT))
                       && (commit_pc != r_expected);
  assign w_self_loop = (commit_pc == commit_pre_pc);
  assign w_timeout   = (r_state == TRC_RUN) && !commit && (r_wdog == WD_W'(TIMEOUT - 1));

  assign w_pop    = trace_valid && trace_ready;
  assign w_push   = w_accept && (!w_full || w_pop);
  assign w_drop   = w_accept && w_full && !w_pop;
  assign w_rec_in = {r_retired, commit_pc, commit_pre_pc, w_err};

  trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_rec_in),
    .o_full  (w_full),
    .o_valid (trace_valid),
    .i_ready (trace_ready),
    .o_data  (w_rec_out)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= TRC_IDLE;
    else     r_state <= w_next_state;
  end

  // Continuity error outranks self-loop detection on the same commit.
  always_comb begin
    w_next_state  = r_state;
    w_fault_event = FC_NONE;
    case (r_state)
      TRC_IDLE: begin
        if (commit) w_next_state = w_self_loop ? TRC_HALT : TRC_RUN;
      end
      TRC_RUN: begin
        if (w_timeout) begin
          w_next_state  = TRC_FAULT;
          w_fault_event = FC_TIMEOUT;
        end else if (commit && w_err) begin
          w_next_state  = TRC_FAULT;
          w_fault_event = FC_PC_MISMATCH;
        end else if (commit && w_self_loop) begin
          w_next_state = TRC_HALT;
        end
      end
      TRC_HALT: begin
        if (commit && !w_halt_hit) begin
          w_next_state  = TRC_FAULT;
          w_fault_event = FC_AFTER_HALT;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_o     = r_state;
    fault_cause = r_fault_cause;
    fault_pc    = r_fault_pc;
    overflow    = r_overflow;
    drop_cnt    = r_drop_cnt;
    retired     = r_retired;
    trace_seq   = w_rec_out[REC_W-1 -: SEQ_W];
    trace_pc    = w_rec_out[2*PC_W : PC_W+1];
    trace_npc   = w_rec_out[PC_W:1];
    trace_err   = w_rec_out[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fault_cause <= FC_NONE;
      r_fault_pc    <= '0;
      r_expected    <= '0;
      r_halt_pc     <= '0;
      r_retired     <= '0;
      r_wdog        <= '0;
      r_overflow    <= 1'b0;
      r_drop_cnt    <= '0;
    end else begin
      if (w_accept) begin
        r_retired  <= r_retired + SEQ_W'(1);
        r_expected <= commit_pre_pc;
      end
      if ((r_state != TRC_RUN) || commit) r_wdog <= '0;
      else                                r_wdog <= r_wdog + WD_W'(1);
      if ((w_next_state == TRC_HALT) && (r_state != TRC_HALT)) r_halt_pc <= commit_pc;
      // Only the first fault is latched; later ones are visible solely via record err bits.
      if ((w_fault_event != FC_NONE) && (r_fault_cause == FC_NONE)) begin
        r_fault_cause <= w_fault_event;
        r_fault_pc    <= (w_fault_event == FC_TIMEOUT) ? '0 : commit_pc;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + DROP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_commit_trace_unit.sv
// tb/tb_commit_trace_unit.sv - scoreboard bench for commit_trace_unit
module tb_commit_trace_unit;

  localparam int PC_W    = 32;
  localparam int DEPTH   = 8;
  localparam int SEQ_W   = 32;
  localparam int TIMEOUT = 32;

  typedef struct {
    logic [SEQ_W-1:0] seq;
    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  npc;
    logic             err;
  } rec_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              commit = 1'b0;
  logic [PC_W-1:0]   commit_pc = '0;
  logic [PC_W-1:0]   commit_pre_pc = '0;
  logic              trace_valid;
  logic              trace_ready = 1'b0;
  logic [SEQ_W-1:0]  trace_seq;
  logic [PC_W-1:0]   trace_pc;
  logic [PC_W-1:0]   trace_npc;
  logic              trace_err;
  logic [1:0]        state_o;
  logic [1:0]        fault_cause;
  logic [PC_W-1:0]   fault_pc;
  logic              overflow;
  logic [15:0]       drop_cnt;
  logic [SEQ_W-1:0]  retired;

  rec_t q[$];
  rec_t m_exp;
  int   n_checks = 0;
  int   n_errors = 0;

  commit_trace_unit #(
    .PC_W    (PC_W),
    .DEPTH   (DEPTH),
    .SEQ_W   (SEQ_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .commit        (commit),
    .commit_pc     (commit_pc),
    .commit_pre_pc (commit_pre_pc),
    .trace_valid   (trace_valid),
    .trace_ready   (trace_ready),
    .trace_seq     (trace_seq),
    .trace_pc      (trace_pc),
    .trace_npc     (trace_npc),
    .trace_err     (trace_err),
    .state_o       (state_o),
    .fault_cause   (fault_cause),
    .fault_pc      (fault_pc),
    .overflow      (overflow),
    .drop_cnt      (drop_cnt),
    .retired       (retired)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && trace_valid && trace_ready) begin
      n_checks++;
      if (q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_record: got seq=%0d pc=0x%0h, none expected", trace_seq, trace_pc);
      end else begin
        m_exp = q.pop_front();
        if (trace_seq !== m_exp.seq || trace_pc !== m_exp.pc ||
            trace_npc !== m_exp.npc || trace_err !== m_exp.err) begin
          n_errors++;
          $display("FAIL record: got seq=%0d pc=0x%0h npc=0x%0h err=%0b expected seq=%0d pc=0x%0h npc=0x%0h err=%0b",
                   trace_seq, trace_pc, trace_npc, trace_err,
                   m_exp.seq, m_exp.pc, m_exp.npc, m_exp.err);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cmt(input logic [PC_W-1:0] pc, input logic [PC_W-1:0] npc,
                     input bit push, input logic [SEQ_W-1:0] seq, input logic err);
    rec_t r;
    if (push) begin
      r.seq = seq; r.pc = pc; r.npc = npc; r.err = err;
      q.push_back(r);
    end
    commit = 1'b1; commit_pc = pc; commit_pre_pc = npc;
    @(posedge clk); #1;
    commit = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (q.size() != 0 && k < 100) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk(name, 64'(q.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();
    chk("rst_state", 64'(state_o), 64'd0);
    chk("rst_valid", 64'(trace_valid), 64'd0);
    chk("rst_retired", 64'(retired), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    chk("rst_cause", 64'(fault_cause), 64'd0);

    // 1: contiguous stream
    trace_ready = 1'b1;
    cmt(32'h0, 32'h4, 1, 0, 0);
    chk("t1_valid_latency", 64'(trace_valid), 64'd1);
    cmt(32'h4, 32'h8, 1, 1, 0);
    cmt(32'h8, 32'hC, 1, 2, 0);
    chk("t1_state", 64'(state_o), 64'd1);
    chk("t1_retired", 64'(retired), 64'd3);
    drain("t1_drain");
    idle(2);
    chk("t1_empty", 64'(trace_valid), 64'd0);

    // 2: pc mismatch
    do_reset();
    cmt(32'h0, 32'h4, 1, 0, 0);
    cmt(32'h20, 32'h24, 1, 1, 1);
    chk("t2_state", 64'(state_o), 64'd3);
    chk("t2_cause", 64'(fault_cause), 64'd1);
    chk("t2_fpc", 64'(fault_pc), 64'h20);
    cmt(32'h100, 32'h104, 1, 2, 1);
    chk("t2_cause_hold", 64'(fault_cause), 64'd1);
    chk("t2_fpc_hold", 64'(fault_pc), 64'h20);
    drain("t2_drain");

    // 3: self-loop halt, then commit after halt
    do_reset();
    cmt(32'h40, 32'h40, 1, 0, 0);
    for (int i = 0; i < 4; i++) cmt(32'h40, 32'h40, 0, 0, 0);
    chk("t3_state", 64'(state_o), 64'd2);
    chk("t3_retired", 64'(retired), 64'd1);
    idle(TIMEOUT + 8);
    chk("t3_halt_no_wdog", 64'(state_o), 64'd2);
    cmt(32'h44, 32'h48, 1, 1, 0);
    chk("t3_fault_state", 64'(state_o), 64'd3);
    chk("t3_cause", 64'(fault_cause), 64'd3);
    chk("t3_fpc", 64'(fault_pc), 64'h44);
    drain("t3_drain");

    // 4: overflow with ready low, then push+pop on full
    do_reset();
    trace_ready = 1'b0;
    for (int i = 0; i < DEPTH + 3; i++)
      cmt(PC_W'(i * 4), PC_W'(i * 4 + 4), i < DEPTH, SEQ_W'(i), 0);
    chk("t4_overflow", 64'(overflow), 64'd1);
    chk("t4_drop", 64'(drop_cnt), 64'd3);
    chk("t4_retired", 64'(retired), 64'(DEPTH + 3));
    chk("t4_head_seq", 64'(trace_seq), 64'd0);
    trace_ready = 1'b1;
    cmt(PC_W'((DEPTH + 3) * 4), PC_W'((DEPTH + 4) * 4), 1, SEQ_W'(DEPTH + 3), 0);
    chk("t4_full_pushpop_drop", 64'(drop_cnt), 64'd3);
    chk("t4_retired2", 64'(retired), 64'(DEPTH + 4));
    drain("t4_drain");

    // 5: watchdog
    do_reset();
    idle(TIMEOUT + 5);
    chk("t5_idle_no_wdog", 64'(state_o), 64'd0);
    cmt(32'h0, 32'h4, 1, 0, 0);
    idle(TIMEOUT - 1);
    chk("t5_before_timeout", 64'(state_o), 64'd1);
    idle(1);
    chk("t5_timeout_state", 64'(state_o), 64'd3);
    chk("t5_cause", 64'(fault_cause), 64'd2);
    chk("t5_fpc", 64'(fault_pc), 64'd0);
    drain("t5_drain");

    // 6: reset mid-stream
    do_reset();
    trace_ready = 1'b0;
    cmt(32'h0, 32'h4, 1, 0, 0);
    cmt(32'h8, 32'hC, 1, 1, 1);
    cmt(32'hC, 32'h10, 1, 2, 0);
    cmt(32'h10, 32'h14, 1, 3, 0);
    cmt(32'h14, 32'h18, 1, 4, 0);
    chk("t6_pre_valid", 64'(trace_valid), 64'd1);
    chk("t6_pre_state", 64'(state_o), 64'd3);
    do_reset();
    chk("t6_valid", 64'(trace_valid), 64'd0);
    chk("t6_state", 64'(state_o), 64'd0);
    chk("t6_retired", 64'(retired), 64'd0);
    chk("t6_cause", 64'(fault_cause), 64'd0);
    chk("t6_fpc", 64'(fault_pc), 64'd0);
    chk("t6_overflow", 64'(overflow), 64'd0);
    trace_ready = 1'b1;
    cmt(32'h80, 32'h84, 1, 0, 0);
    chk("t6_post_state", 64'(state_o), 64'd1);
    drain("t6_drain");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
